// File: rtl/cnn_layer_accel_slave_regs.sv
// rtl/cnn_layer_accel_slave_regs.sv - SAP slave register file with doorbell command FIFO
//
// Terminates SAP slave bursts into C_NUM_SLAVE_REGS 128-bit registers. The
// highest register index is a doorbell. Writes to it are queued as command
// packets in a C_FIFO_DEPTH-entry FIFO. Reads of it return the FIFO status.
//
// Ports:
//   clk, rst                      single clock; asynchronous active-low reset
//   slave_burst_length/_rnw/_address/_address_valid -> slave_address_ack
//                                 address phase, acknowledged only in IDLE
//   slave_wrreq/_be/_datain -> slave_wrack
//                                 write beats, byte-enabled
//   slave_rdreq -> slave_rdack, slave_dataout
//                                 zero-wait-state read beats
//   cfg_regs                      flat register contents (doorbell slot is 0)
//   ctrl_output_valid/_accept/_data
//                                 command packet stream, data is the FIFO head
//
// C_NUM_SLAVE_REGS >= 2 and C_FIFO_DEPTH >= 2 must both be powers of two.
// C_PACKET_WIDTH must be 128.
module cnn_layer_accel_slave_regs #(
   parameter int C_NUM_SLAVE_REGS = 8,
   parameter int C_PACKET_WIDTH   = 128,
   parameter int C_FIFO_DEPTH     = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [12:0]                     slave_burst_length,
   input  logic                            slave_burst_rnw,
   input  logic [63:0]                     slave_address,
   input  logic                            slave_address_valid,
   output logic                            slave_address_ack,
   input  logic [3:0]                      slave_wrreq,
   output logic                            slave_wrack,
   input  logic [15:0]                     slave_be,
   input  logic [127:0]                    slave_datain,
   input  logic [3:0]                      slave_rdreq,
   output logic                            slave_rdack,
   output logic [127:0]                    slave_dataout,
   output logic [C_NUM_SLAVE_REGS*128-1:0] cfg_regs,
   output logic                            ctrl_output_valid,
   input  logic                            ctrl_output_accept,
   output logic [C_PACKET_WIDTH-1:0]       ctrl_output_data
);

   localparam int IDX_W = $clog2(C_NUM_SLAVE_REGS);
   localparam int PTR_W = $clog2(C_FIFO_DEPTH);
   localparam int CNT_W = $clog2(C_FIFO_DEPTH) + 1;
   localparam logic [IDX_W-1:0] DB_IDX = IDX_W'(C_NUM_SLAVE_REGS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WR,
      S_RD
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [IDX_W-1:0]    idx_q;
   logic                oor_q;
   logic [12:0]         beats_q;

   logic                addr_oor;
   logic                cur_is_db;
   logic                last_beat;
   logic                beat_ack;
   logic [127:0]        be_mask;
   logic [127:0]        status_word;

   logic [127:0]        regs_q [C_NUM_SLAVE_REGS];
   logic                reg_we;

   logic [C_PACKET_WIDTH-1:0] fifo_mem [C_FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    fifo_cnt;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;
   logic                fifo_pop;
   logic [C_PACKET_WIDTH-1:0] push_data;

   // Only bit 0 of the request vectors is meaningful, and the in-beat byte offset is ignored.
   logic                unused_inputs;
   assign unused_inputs = ^{slave_address[3:0], slave_wrreq[3:1], slave_rdreq[3:1]};

   // Any address bit above the index field makes the whole burst out of range.
   assign addr_oor  = |slave_address[63:4+IDX_W];
   // Out-of-range beats never count as doorbell beats, so they never stall on a full FIFO.
   assign cur_is_db = (idx_q == DB_IDX) && !oor_q;
   assign last_beat = (beats_q == 13'd1);
   assign beat_ack  = slave_wrack | slave_rdack;

   assign fifo_full  = (fifo_cnt == CNT_W'(C_FIFO_DEPTH));
   assign fifo_empty = (fifo_cnt == '0);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      slave_address_ack = 1'b0;
      slave_wrack       = 1'b0;
      slave_rdack       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (slave_address_valid) begin
               slave_address_ack = 1'b1;
               state_d           = slave_burst_rnw ? S_RD : S_WR;
            end
         end
         S_WR: begin
            slave_wrack = slave_wrreq[0] && !(cur_is_db && fifo_full);
            if (slave_wrack && last_beat) begin
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            slave_rdack = slave_rdreq[0];
            if (slave_rdack && last_beat) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- burst tracking ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q   <= '0;
         oor_q   <= 1'b0;
         beats_q <= '0;
      end else if (slave_address_ack) begin
         idx_q   <= slave_address[4 +: IDX_W];
         oor_q   <= addr_oor;
         beats_q <= (slave_burst_length == 13'd0) ? 13'd1 : slave_burst_length;
      end else if (beat_ack) begin
         // Natural IDX_W-bit overflow gives the modulo-register-count wrap.
         idx_q   <= idx_q + 1'b1;
         beats_q <= beats_q - 1'b1;
      end
   end

   // ---------------- register file ----------------
   always_comb begin
      be_mask = '0;
      for (int b = 0; b < 16; b++) begin
         be_mask[8*b +: 8] = {8{slave_be[b]}};
      end
   end

   assign reg_we = slave_wrack && !oor_q && !cur_is_db;

   // The doorbell slot is never written here, so it stays 0 on cfg_regs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < C_NUM_SLAVE_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (reg_we) begin
         for (int b = 0; b < 16; b++) begin
            if (slave_be[b]) begin
               regs_q[idx_q][8*b +: 8] <= slave_datain[8*b +: 8];
            end
         end
      end
   end

   for (genvar g = 0; g < C_NUM_SLAVE_REGS; g++) begin : g_cfg
      assign cfg_regs[g*128 +: 128] = regs_q[g];
   end

   // ---------------- readback ----------------
   always_comb begin
      status_word      = '0;
      status_word[7:0] = 8'(fifo_cnt);
      status_word[8]   = fifo_full;
      status_word[9]   = fifo_empty;
   end

   always_comb begin
      slave_dataout = '0;
      if (slave_rdack && !oor_q) begin
         slave_dataout = cur_is_db ? status_word : regs_q[idx_q];
      end
   end

   // ---------------- doorbell FIFO ----------------
   assign push_data = slave_datain & be_mask;
   assign fifo_push = slave_wrack && cur_is_db;
   assign fifo_pop  = ctrl_output_valid && ctrl_output_accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < C_FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (fifo_push) begin
            fifo_mem[wr_ptr] <= push_data;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   assign ctrl_output_valid = !fifo_empty;
   // Gated so a drained FIFO presents zero rather than a stale packet.
   assign ctrl_output_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];

endmodule

// File: tb/tb_cnn_layer_accel_slave_regs.sv
// tb/tb_cnn_layer_accel_slave_regs.sv - scoreboard bench for cnn_layer_accel_slave_regs
module tb_cnn_layer_accel_slave_regs;

   localparam int N     = 8;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [12:0]       slave_burst_length;
   logic              slave_burst_rnw;
   logic [63:0]       slave_address;
   logic              slave_address_valid;
   logic              slave_address_ack;
   logic [3:0]        slave_wrreq;
   logic              slave_wrack;
   logic [15:0]       slave_be;
   logic [127:0]      slave_datain;
   logic [3:0]        slave_rdreq;
   logic              slave_rdack;
   logic [127:0]      slave_dataout;
   logic [N*128-1:0]  cfg_regs;
   logic              ctrl_output_valid;
   logic              ctrl_output_accept;
   logic [127:0]      ctrl_output_data;

   always #5 clk = ~clk;

   cnn_layer_accel_slave_regs #(
      .C_NUM_SLAVE_REGS (N),
      .C_PACKET_WIDTH   (128),
      .C_FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .slave_burst_length  (slave_burst_length),
      .slave_burst_rnw     (slave_burst_rnw),
      .slave_address       (slave_address),
      .slave_address_valid (slave_address_valid),
      .slave_address_ack   (slave_address_ack),
      .slave_wrreq         (slave_wrreq),
      .slave_wrack         (slave_wrack),
      .slave_be            (slave_be),
      .slave_datain        (slave_datain),
      .slave_rdreq         (slave_rdreq),
      .slave_rdack         (slave_rdack),
      .slave_dataout       (slave_dataout),
      .cfg_regs            (cfg_regs),
      .ctrl_output_valid   (ctrl_output_valid),
      .ctrl_output_accept  (ctrl_output_accept),
      .ctrl_output_data    (ctrl_output_data)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: register array, FIFO occupancy, burst cursor, expected responses.
   logic [127:0] m_regs [N];
   int           m_cnt;
   int           m_idx;
   bit           m_oor;
   int           acc_mode;   // 0 never accept, 1 random, 2 pulse on 4th stalled cycle, 3 always
   logic [127:0] exp_pkt [$];
   logic [127:0] exp_rd  [$];

   function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [127:0] bmask(input logic [15:0] be);
      logic [127:0] m = '0;
      for (int b = 0; b < 16; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic bit m_is_db();
      return (m_idx == N - 1) && !m_oor;
   endfunction

   function automatic logic [127:0] m_read();
      logic [127:0] s = '0;
      if (m_oor) return '0;
      if (!m_is_db()) return m_regs[m_idx];
      s[7:0] = 8'(m_cnt);
      s[8]   = (m_cnt == DEPTH);
      s[9]   = (m_cnt == 0);
      return s;
   endfunction

   function automatic logic pick_acc(int stall);
      case (acc_mode)
         1:       return 1'($urandom_range(0, 1));
         2:       return (stall == 3);
         3:       return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Monitor: compares every read beat and every accepted packet against the queues.
   always @(negedge clk) begin
      if (rst) begin
         if (slave_rdack) begin
            if (exp_rd.size() == 0) begin
               total++; bad++;
               $display("FAIL rd_unexpected: got rdack with data %h, no read expected", slave_dataout);
            end else begin
               check("rd_data", slave_dataout, exp_rd.pop_front());
            end
         end else begin
            check("rd_idle_zero", slave_dataout, '0);
         end
         if (ctrl_output_valid && ctrl_output_accept) begin
            if (exp_pkt.size() == 0) begin
               total++; bad++;
               $display("FAIL pkt_unexpected: got packet %h, none expected", ctrl_output_data);
            end else begin
               check("pkt_data", ctrl_output_data, exp_pkt.pop_front());
            end
         end
      end
   end

   task automatic clear_inputs();
      slave_address_valid = 1'b0;
      slave_wrreq         = 4'b0;
      slave_rdreq         = 4'b0;
      ctrl_output_accept  = 1'b0;
   endtask

   task automatic addr_phase(input logic [63:0] a, input logic [12:0] len, input logic rnw);
      @(posedge clk); #1;
      clear_inputs();
      slave_address       = a;
      slave_burst_length  = len;
      slave_burst_rnw     = rnw;
      slave_address_valid = 1'b1;
      @(negedge clk);
      check("addr_ack", slave_address_ack, 1'b1);
      m_idx = int'(a[6:4]);
      m_oor = (a[63:7] != '0);
   endtask

   task automatic wr_beat(input logic [127:0] d, input logic [15:0] be);
      int  stall = 0;
      bit  done  = 0;
      bit  exp_ack;
      bit  pop_now;
      while (!done) begin
         @(posedge clk); #1;
         slave_address_valid = 1'b0;
         slave_rdreq         = 4'b0;
         slave_wrreq         = {3'($urandom), 1'b1};
         slave_datain        = d;
         slave_be            = be;
         ctrl_output_accept  = pick_acc(stall);
         @(negedge clk);
         exp_ack = !(m_is_db() && m_cnt == DEPTH);
         pop_now = ctrl_output_accept && (m_cnt > 0);
         check("wrack", slave_wrack, exp_ack);
         if (exp_ack) begin
            if (!m_oor) begin
               if (m_is_db()) begin
                  exp_pkt.push_back(d & bmask(be));
                  m_cnt++;
               end else begin
                  for (int b = 0; b < 16; b++)
                     if (be[b]) m_regs[m_idx][8*b +: 8] = d[8*b +: 8];
               end
            end
            m_idx = (m_idx + 1) % N;
            done  = 1;
         end else begin
            stall++;
            if (stall > 40) begin
               total++; bad++;
               $display("FAIL wrack_timeout: got no wrack after %0d cycles, required ack", stall);
               done = 1;
            end
         end
         if (pop_now) m_cnt--;
      end
   endtask

   task automatic rd_beat();
      @(posedge clk); #1;
      slave_address_valid = 1'b0;
      slave_wrreq         = 4'b0;
      slave_rdreq         = {3'($urandom), 1'b1};
      ctrl_output_accept  = pick_acc(0);
      exp_rd.push_back(m_read());
      @(negedge clk);
      check("rdack", slave_rdack, 1'b1);
      if (ctrl_output_accept && m_cnt > 0) m_cnt--;
      m_idx = (m_idx + 1) % N;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic check_regs();
      for (int i = 0; i < N; i++)
         check($sformatf("cfg_reg%0d", i), cfg_regs[i*128 +: 128], m_regs[i]);
   endtask

   task automatic drain();
      int guard = 0;
      while (m_cnt > 0 && guard < 20) begin
         @(posedge clk); #1;
         clear_inputs();
         ctrl_output_accept = 1'b1;
         @(negedge clk);
         check("drain_valid", ctrl_output_valid, 1'b1);
         m_cnt--;
         guard++;
      end
      idle_cycle();
      check("drained_valid", ctrl_output_valid, 1'b0);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic reset_outputs_check(string tag);
      check({tag, "_addr_ack"}, slave_address_ack, 1'b0);
      check({tag, "_wrack"}, slave_wrack, 1'b0);
      check({tag, "_rdack"}, slave_rdack, 1'b0);
      check({tag, "_dataout"}, slave_dataout, '0);
      check({tag, "_valid"}, ctrl_output_valid, 1'b0);
      check({tag, "_pkt_data"}, ctrl_output_data, '0);
      for (int i = 0; i < N; i++)
         check($sformatf("%s_cfg%0d", tag, i), cfg_regs[i*128 +: 128], '0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_regs[i] = '0;
      m_cnt = 0; m_idx = 0; m_oor = 0;
      exp_pkt.delete();
      exp_rd.delete();
   endtask

   initial begin
      #500000;
      total++; bad++;
      $display("FAIL watchdog: got simulation still running, required completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      rst = 1'b0;
      clear_inputs();
      slave_address = '0; slave_burst_length = '0; slave_burst_rnw = 1'b0;
      slave_be = '0; slave_datain = '0;
      acc_mode = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_outputs_check("reset");
      @(posedge clk); #1;
      rst = 1'b1;
      idle_cycle();

      // Full write, single-byte merge, readback.
      addr_phase(64'h10, 13'd1, 1'b0); wr_beat({16{8'h11}}, 16'hFFFF);
      addr_phase(64'h10, 13'd1, 1'b0); wr_beat(128'hAB, 16'h0001);
      addr_phase(64'h10, 13'd0, 1'b1); rd_beat();
      idle_cycle();
      check_regs();

      // 3-beat burst from index 5 ends on the doorbell.
      addr_phase(64'h50, 13'd3, 1'b0);
      for (int k = 0; k < 3; k++) wr_beat(rnd128(), 16'hFFFF);
      check("db_valid_same_cycle", ctrl_output_valid, 1'b0);
      idle_cycle();
      check("db_valid_next_cycle", ctrl_output_valid, 1'b1);
      check_regs();
      drain();

      // Fill the FIFO, stall the fifth doorbell, release it with one accept.
      acc_mode = 0;
      for (int k = 0; k < 4; k++) begin
         addr_phase(64'h70, 13'd1, 1'b0); wr_beat(rnd128(), 16'($urandom));
      end
      acc_mode = 2;
      addr_phase(64'h70, 13'd1, 1'b0); wr_beat(rnd128(), 16'hFFFF);
      acc_mode = 0;
      addr_phase(64'h70, 13'd1, 1'b1); rd_beat();
      drain();

      // Push and pop in the same cycle at count 2.
      for (int k = 0; k < 2; k++) begin
         addr_phase(64'h70, 13'd1, 1'b0); wr_beat(rnd128(), 16'hFFFF);
      end
      acc_mode = 3;
      addr_phase(64'h70, 13'd1, 1'b0); wr_beat(rnd128(), 16'hF0F0);
      acc_mode = 0;
      addr_phase(64'h70, 13'd1, 1'b1); rd_beat();
      drain();

      // Out-of-range read and write.
      addr_phase(64'h1000, 13'd1, 1'b1); rd_beat();
      addr_phase(64'h1000, 13'd2, 1'b0);
      wr_beat(rnd128(), 16'hFFFF); wr_beat(rnd128(), 16'hFFFF);
      idle_cycle();
      check_regs();

      // Randomized bursts with random downstream accept.
      acc_mode = 1;
      for (int t = 0; t < 60; t++) begin
         logic [63:0] a;
         logic [12:0] len;
         logic        rnw;
         a   = {60'b0, 4'($urandom)};
         a[6:4] = 3'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            a[63:7] = {$urandom, 25'($urandom)};
            if (a[63:7] == '0) a[7] = 1'b1;
         end
         len = 13'($urandom_range(0, 4));
         rnw = 1'($urandom);
         addr_phase(a, len, rnw);
         for (int k = 0; k < ((len == 0) ? 1 : int'(len)); k++) begin
            if (rnw) rd_beat();
            else wr_beat(rnd128(), ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
         end
         idle_cycle();
         check_regs();
      end
      acc_mode = 0;
      drain();

      // Reset mid-burst with a packet waiting in the FIFO.
      addr_phase(64'h70, 13'd1, 1'b0); wr_beat(rnd128(), 16'hFFFF);
      addr_phase(64'h10, 13'd4, 1'b0);
      wr_beat(rnd128(), 16'hFFFF); wr_beat(rnd128(), 16'hFFFF);
      @(posedge clk); #1;
      rst = 1'b0;
      #2;
      model_reset();
      reset_outputs_check("midreset");
      idle_cycle();
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      addr_phase(64'h20, 13'd1, 1'b0); wr_beat(rnd128(), 16'hFFFF);
      addr_phase(64'h20, 13'd1, 1'b1); rd_beat();
      idle_cycle();
      check_regs();
      check("final_rd_queue_empty", 128'(exp_rd.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cnn_layer_accel_slave_regs.md
# cnn_layer_accel_slave_regs

Register file and doorbell stage that sits directly downstream of the SAP slave interface of `cnn_layer_accel`. It terminates slave bursts, holds 128-bit configuration registers with byte-enable writes and readback, and forwards doorbell writes as command packets into the layer-engine control packet path through a 4-entry FIFO with valid/accept handshake.

## Interface
Parameters:
- C_NUM_SLAVE_REGS, 8, number of 128-bit registers including the doorbell; power of two, at least 2
- C_PACKET_WIDTH, 128, command packet width; must be 128
- C_FIFO_DEPTH, 4, doorbell FIFO depth; power of two

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  reset, asynchronous, active-low
- slave_burst_length  in  13  burst length in 16-byte beats, sampled with the address; 0 is treated as 1
- slave_burst_rnw  in  1  1 = read burst, 0 = write burst
- slave_address  in  64  byte address of the first beat
- slave_address_valid  in  1  address phase request
- slave_address_ack  out  1  address accepted
- slave_wrreq  in  4  write beat request; only bit 0 is used
- slave_wrack  out  1  write beat accepted
- slave_be  in  16  byte enables; bit i enables datain[8i+7:8i]
- slave_datain  in  128  write data
- slave_rdreq  in  4  read beat request; only bit 0 is used
- slave_rdack  out  1  read beat returned
- slave_dataout  out  128  read data, valid while rdack = 1
- cfg_regs  out  C_NUM_SLAVE_REGS*128  flat register contents; the doorbell slot reads as 0
- ctrl_output_valid  out  1  command packet valid
- ctrl_output_accept  in  1  downstream accepts the packet
- ctrl_output_data  out  C_PACKET_WIDTH  command packet, which is the FIFO head

## Operation
- Register index = address[4 +: log2(C_NUM_SLAVE_REGS)]. Address bits [3:0] are ignored. Higher address bits are out of range when nonzero.
- Doorbell = index C_NUM_SLAVE_REGS-1. All other indices are plain read/write registers.
- FSM states: IDLE, WR, RD.
  - IDLE: when address_valid is asserted, assert address_ack combinationally for that cycle. Latch the index, the out-of-range flag, and beats = max(burst_length,1). Go to WR or RD according to rnw.
  - Address ack is only issued in IDLE.
- WR state, per beat:
  - wrack = wrreq[0] AND NOT (index is the doorbell AND FIFO full).
  - On wrack for a plain register, merge the data per byte using be.
  - On wrack for the doorbell, push be-masked datain into the FIFO. Disabled bytes are 0.
  - Out-of-range beats are acked and their data is dropped.
  - Index increments by 1 per acked beat and wraps modulo C_NUM_SLAVE_REGS. The out-of-range flag is held for the whole burst.
  - Decrement the beat counter on each ack. The last beat returns to IDLE.
- RD state, per beat:
  - rdack = rdreq[0]. dataout is driven combinationally from the current index.
  - Doorbell reads return a status word: {fifo count in bits [7:0], full in bit 8, empty in bit 9}, with all other bits 0.
  - Out-of-range reads return 0.
  - Index and beat counter update as in WR. The last beat returns to IDLE.
- FIFO:
  - ctrl_output_valid = NOT empty.
  - Pop on valid AND accept.
  - A push and a pop in the same cycle while full is not allowed, because wrack is gated by full in that cycle.
  - A push and a pop in the same cycle in any other state leaves count unchanged and the data in order.
- slave_dataout = 0 whenever rdack = 0.

## Timing
- Reset values:
  - FSM in IDLE.
  - All registers 0.
  - FIFO empty, count 0.
  - address_ack, wrack, rdack = 0.
  - dataout = 0.
  - ctrl_output_valid = 0, ctrl_output_data = 0.
- Asserting reset in the middle of a burst aborts the burst immediately, discards FIFO contents, and drives all outputs to their reset values on the next clock-independent evaluation.
- Write latency: a register update is visible on cfg_regs and on readback on the cycle after wrack.
- Doorbell latency: ctrl_output_valid rises on the cycle after the acked doorbell write.
- Read data: zero-wait-state, in the same cycle as rdreq.
- Valid/accept rule: once ctrl_output_valid = 1, data is held stable until accepted.

## Test plan
- Reset, then write 0x11..11 with be=0xFFFF to addr 0x10 -> index 1 = 0x11..11. Then write be=0x0001 data 0xAB -> byte 0 = 0xAB, other bytes unchanged. Read back gives 0x11..11AB.
- 3-beat write burst at addr 0x50 (index 5, N=8) -> indices 5, 6, 7 are written. Index 7 is the doorbell, so one packet appears with ctrl_output_valid 1 cycle after that beat.
- 5 doorbell writes (addr 0x70) with accept held 0 -> the first 4 get wrack. The 5th is stalled with wrack=0 and a status read is not possible during the burst. Pulse accept once -> the 5th is acked and the packet order is preserved.
- With the FIFO at count 2, a doorbell push and an accept in the same cycle -> count stays 2 and the head advances.
- Read of addr 0x1000 (out of range) -> address_ack, rdack, dataout=0. Write there -> wrack, and no register changes.
- Assert rst low in the middle of a 4-beat write after beat 2 -> beats 1-2 are lost, because registers reset to 0, and the FSM is in IDLE. After release, address_ack responds to a new request.
